kernel_stream_sink: RTL and testbench

- Terminal node of a TyTra map pipeline. It consumes the registered result stream from the leaf map nodes (in1 + in2 style datapath) and buffers it in a small FIFO.
- It drains words to a valid/ready output port (memory writer or host stream).
- It generates the pipeline-wide `stall` that every leaf node obeys: hold output when `stall`=1.
- It counts drained words and flags completion.

---
 rtl/tytra_pkg.sv | 12 +
 rtl/tytra_sync_fifo.sv | 41 ++++
 rtl/kernel_stream_sink.sv | 46 ++++
 tb/tb_kernel_stream_sink.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tytra_pkg.sv
// tytra_pkg: shared widths and sizing helpers for TyTra pipeline nodes
package tytra_pkg;
  localparam int DATAW_DEF = 32;
  localparam int DEPTH_DEF = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  localparam int PTRW_DEF = clog2(DEPTH_DEF);
endpackage

// File: rtl/tytra_sync_fifo.sv
// tytra_sync_fifo: single-clock FIFO exposing next-cycle occupancy for early stall
module tytra_sync_fifo import tytra_pkg::*; #(
  parameter int DATAW = DATAW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PTRW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [DATAW-1:0] wdata,
  output logic [DATAW-1:0] rdata,
  output logic [PTRW:0]    count_next,
  output logic             full,
  output logic             empty
);
  logic [DATAW-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr, rd_ptr;
  logic [PTRW:0]    count;
  logic             we, re;
  assign full       = count == (PTRW+1)'(DEPTH);
  assign empty      = count == '0;
  assign we         = wr & ~full;
  assign re         = rd & ~empty;
  assign count_next = count + (PTRW+1)'(we) - (PTRW+1)'(re);
  assign rdata      = empty ? '0 : mem[rd_ptr];
  // storage has no reset; pointers and count alone define what is live
  always_ff @(posedge clk)
    if (we) mem[wr_ptr] <= wdata;
  // pointers wrap naturally at DEPTH because DEPTH is a power of two
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (we) wr_ptr <= wr_ptr + PTRW'(1);
      if (re) rd_ptr <= rd_ptr + PTRW'(1);
      count <= count_next;
    end
endmodule

// File: rtl/kernel_stream_sink.sv
// kernel_stream_sink: buffers the pipeline result stream, drives stall, counts drained words
module kernel_stream_sink import tytra_pkg::*; #(
  parameter int DATAW = DATAW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int SLACK = 2,
  parameter int CNTW  = 32,
  localparam int PTRW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DATAW-1:0] in1,
  input  logic             in1_valid,
  output logic             stall,
  output logic [DATAW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [CNTW-1:0]  n_words,
  output logic             done,
  output logic             ovf_err
);
  localparam logic [PTRW:0] THR = (PTRW+1)'(DEPTH - SLACK);
  logic            wr, rd, full, empty;
  logic [PTRW:0]   count_next;
  logic [CNTW-1:0] drained, drained_next;
  assign wr           = in1_valid & ~stall;
  assign rd           = out_valid & out_ready;
  assign out_valid    = ~empty;
  assign drained_next = (rd && drained < n_words) ? drained + CNTW'(1) : drained;
  tytra_sync_fifo #(.DATAW(DATAW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .wdata(in1), .rdata(out_data),
    .count_next(count_next), .full(full), .empty(empty)
  );
  // stall looks at next occupancy so the leaves see it before the slack is used up
  always_ff @(posedge clk)
    if (rst) begin
      stall   <= 1'b0;
      drained <= '0;
      done    <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      stall   <= count_next >= THR;
      drained <= drained_next;
      done    <= done | (drained_next >= n_words);
      ovf_err <= ovf_err | (wr & full);
    end
endmodule

// File: tb/tb_kernel_stream_sink.sv
// tb_kernel_stream_sink: directed checks of buffering, stall, ordering, done and reset
module tb_kernel_stream_sink;
  logic        clk = 0, rst = 1, in1_valid = 0, out_ready = 0;
  logic [31:0] in1 = 0, n_words = 1000;
  logic        stall, out_valid, done, ovf_err;
  logic [31:0] out_data;
  int          nchk = 0, nerr = 0, rx_n = 0;
  logic [31:0] tx[$];
  logic [31:0] rx_exp[$];

  kernel_stream_sink #(.DATAW(32), .DEPTH(8), .SLACK(2), .CNTW(32)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in1_valid(in1_valid), .stall(stall),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .n_words(n_words), .done(done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input int n);
    rst = 1;
    in1_valid = 0;
    tx.delete();
    rx_exp.delete();
    repeat (n) step();
    rst = 0;
  endtask

  // upstream holds its word while stall is high; downstream pops are scoreboarded
  task automatic cyc();
    logic acc, pop;
    logic [31:0] w;
    in1_valid = tx.size() > 0;
    in1 = (tx.size() > 0) ? tx[0] : 32'h0;
    acc = in1_valid && !stall;
    pop = out_valid && out_ready;
    w = out_data;
    step();
    if (acc) void'(tx.pop_front());
    if (pop) begin
      rx_n++;
      chk("rx_expected", 32'(rx_exp.size() > 0), 32'd1);
      if (rx_exp.size() > 0) chk("rx_order", w, rx_exp.pop_front());
    end
    in1_valid = tx.size() > 0;
    in1 = (tx.size() > 0) ? tx[0] : 32'h0;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && (tx.size() > 0 || rx_exp.size() > 0 || out_valid); i++) cyc();
    chk("drain_rx_left", rx_exp.size(), 0);
    chk("drain_out_valid", 32'(out_valid), 0);
  endtask

  initial begin
    // reset state
    reset_dut(2);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    chk("rst_out_data", out_data, 0);
    // pass-through, one cycle latency
    out_ready = 1;
    tx = '{32'h10, 32'h11, 32'h12};
    rx_exp = '{32'h10, 32'h11, 32'h12};
    cyc();
    chk("pt_valid0", 32'(out_valid), 1);
    chk("pt_data0", out_data, 32'h10);
    cyc();
    chk("pt_data1", out_data, 32'h11);
    cyc();
    chk("pt_data2", out_data, 32'h12);
    chk("pt_stall", 32'(stall), 0);
    drain(10);
    // backpressure fill
    out_ready = 0;
    tx = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    rx_exp = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    repeat (5) cyc();
    chk("bp_stall_5", 32'(stall), 0);
    chk("bp_sent_5", 10 - tx.size(), 5);
    cyc();
    chk("bp_stall_6", 32'(stall), 1);
    chk("bp_sent_6", 10 - tx.size(), 6);
    repeat (3) cyc();
    chk("bp_sent_hold", 10 - tx.size(), 6);
    chk("bp_stall_hold", 32'(stall), 1);
    chk("bp_head", out_data, 1);
    chk("bp_ovf", 32'(ovf_err), 0);
    out_ready = 1;
    cyc();
    chk("bp_stall_drop", 32'(stall), 0);
    drain(40);
    // simultaneous push and pop at count 5
    out_ready = 0;
    tx = '{32'h30, 32'h31, 32'h32, 32'h33, 32'h34};
    rx_exp = '{32'h30, 32'h31, 32'h32, 32'h33, 32'h34, 32'h35, 32'h36};
    repeat (5) cyc();
    chk("sim_stall_5", 32'(stall), 0);
    tx.push_back(32'h35);
    out_ready = 1;
    cyc();
    chk("sim_stall_same", 32'(stall), 0);
    chk("sim_head", out_data, 32'h31);
    out_ready = 0;
    tx.push_back(32'h36);
    cyc();
    chk("sim_stall_6", 32'(stall), 1);
    out_ready = 1;
    drain(40);
    // held data while stalled is accepted exactly once
    out_ready = 0;
    tx = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
    rx_exp = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hAA};
    repeat (6) cyc();
    chk("held_stall", 32'(stall), 1);
    tx.push_back(32'hAA);
    repeat (4) cyc();
    chk("held_not_taken", tx.size(), 1);
    out_ready = 1;
    drain(40);
    chk("held_done", 32'(done), 0);
    // reset mid-stream
    out_ready = 0;
    tx = '{32'h40, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45};
    repeat (6) cyc();
    chk("mid_stall_pre", 32'(stall), 1);
    reset_dut(1);
    chk("mid_out_valid", 32'(out_valid), 0);
    chk("mid_stall", 32'(stall), 0);
    chk("mid_done", 32'(done), 0);
    out_ready = 1;
    tx = '{32'h55};
    rx_exp = '{32'h55};
    cyc();
    chk("mid_first", out_data, 32'h55);
    drain(10);
    // done after n_words pops, sticky
    n_words = 5;
    reset_dut(1);
    out_ready = 1;
    rx_n = 0;
    tx = '{32'h60, 32'h61, 32'h62, 32'h63, 32'h64};
    rx_exp = '{32'h60, 32'h61, 32'h62, 32'h63, 32'h64, 32'h65, 32'h66};
    for (int i = 0; i < 20 && rx_n < 4; i++) cyc();
    chk("done_pops4", rx_n, 4);
    chk("done_before", 32'(done), 0);
    cyc();
    chk("done_pops5", rx_n, 5);
    chk("done_after", 32'(done), 1);
    tx = '{32'h65, 32'h66};
    drain(20);
    chk("done_sticky", 32'(done), 1);
    // n_words = 0 completes immediately after reset
    n_words = 0;
    reset_dut(1);
    chk("zero_rst_done", 32'(done), 0);
    step();
    chk("zero_done", 32'(done), 1);
    chk("final_ovf", 32'(ovf_err), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
